fifo_write_arbiter: RTL and testbench

Shares one command FIFO write port among three requesters with packet atomicity, e.g. matrix engine, clipper and host register path feeding the rasterizer command FIFO. Arbitration is round-robin at packet granularity. Once a requester is granted, all of its words up to and including the word flagged last go into the FIFO contiguously. The block drives the FIFO write strobe and data, and backpressures requesters from the FIFO full flag.

---
 rtl/fifo_write_arbiter.sv | 145 ++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Packet-atomic round-robin arbiter that shares one command FIFO write port among
// three requesters; a granted requester keeps the port until its last-flagged word lands.
module fifo_write_arbiter #(
    parameter int WIDTH = 32,
    parameter int RANGE = 2
) (
    input  logic                 clk,
    input  logic                 rst_x,
    input  logic [2:0]           i_req,
    input  logic [2:0]           i_last,
    input  logic [3*WIDTH-1:0]   i_dt,
    output logic [2:0]           o_ack,
    output logic                 o_wstrobe,
    output logic [WIDTH-1:0]     o_dt,
    input  logic                 i_full,
    input  logic [RANGE:0]       i_dnum,
    output logic [2:0]           o_grant,
    output logic                 o_busy,
    output logic [15:0]          o_pkt_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic        busy_q, busy_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [15:0] pkt_cnt_q, pkt_cnt_d;

    logic [2:0]  winner;
    logic [1:0]  next_ptr;
    logic        pkt_end;
    logic        dnum_unused;

    // Occupancy is informational only; arbitration reacts to i_full alone.
    assign dnum_unused = ^i_dnum;

    always_comb begin
        winner = 3'b000;
        case (ptr_q)
            2'd1: begin
                if (i_req[1])      winner = 3'b010;
                else if (i_req[2]) winner = 3'b100;
                else if (i_req[0]) winner = 3'b001;
            end
            2'd2: begin
                if (i_req[2])      winner = 3'b100;
                else if (i_req[0]) winner = 3'b001;
                else if (i_req[1]) winner = 3'b010;
            end
            default: begin
                if (i_req[0])      winner = 3'b001;
                else if (i_req[1]) winner = 3'b010;
                else if (i_req[2]) winner = 3'b100;
            end
        endcase
    end

    always_comb begin
        next_ptr = 2'd0;
        case (grant_q)
            3'b001:  next_ptr = 2'd1;
            3'b010:  next_ptr = 2'd2;
            default: next_ptr = 2'd0;
        endcase
    end

    always_comb begin
        o_ack = 3'b000;
        if (state_q == XFER && !i_full) begin
            o_ack = grant_q & i_req;
        end
    end

    assign o_wstrobe = |o_ack;
    assign pkt_end   = |(o_ack & i_last);

    always_comb begin
        o_dt = '0;
        case (grant_q)
            3'b001:  o_dt = i_dt[0*WIDTH +: WIDTH];
            3'b010:  o_dt = i_dt[1*WIDTH +: WIDTH];
            3'b100:  o_dt = i_dt[2*WIDTH +: WIDTH];
            default: o_dt = '0;
        endcase
    end

    // The grant is taken in IDLE and released only by an accepted last word,
    // which forces at least one IDLE cycle between consecutive packets.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        ptr_d     = ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        if (state_q == IDLE) begin
            if (|i_req) begin
                state_d = XFER;
                grant_d = winner;
                busy_d  = 1'b1;
            end
        end else begin
            if (pkt_end) begin
                state_d   = IDLE;
                grant_d   = 3'b000;
                busy_d    = 1'b0;
                ptr_d     = next_ptr;
                pkt_cnt_d = pkt_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state_q   <= IDLE;
            grant_q   <= 3'b000;
            busy_q    <= 1'b0;
            ptr_q     <= 2'd0;
            pkt_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            ptr_q     <= ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign o_grant   = grant_q;
    assign o_busy    = busy_q;
    assign o_pkt_cnt = pkt_cnt_q;

    // A requester must hold its word and last flag stable until the word is acked.
    generate
        for (genvar n = 0; n < 3; n++) begin : g_proto
            a_hold_word: assert property (@(posedge clk) disable iff (!rst_x)
                ($past(i_req[n]) && !$past(o_ack[n]) && i_req[n])
                |-> ($stable(i_last[n]) && $stable(i_dt[n*WIDTH +: WIDTH])));
        end
    endgenerate

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized scoreboard bench for fifo_write_arbiter: a driver issues packets and queues
// the words it offers; a monitor replays round-robin packet arbitration and checks every cycle.
module tb_fifo_write_arbiter;

    localparam int WIDTH = 32;
    localparam int RANGE = 2;

    logic                 clk;
    logic                 rst_x;
    logic [2:0]           i_req;
    logic [2:0]           i_last;
    logic [3*WIDTH-1:0]   i_dt;
    logic [2:0]           o_ack;
    logic                 o_wstrobe;
    logic [WIDTH-1:0]     o_dt;
    logic                 i_full;
    logic [RANGE:0]       i_dnum;
    logic [2:0]           o_grant;
    logic                 o_busy;
    logic [15:0]          o_pkt_cnt;

    fifo_write_arbiter #(.WIDTH(WIDTH), .RANGE(RANGE)) dut (
        .clk       (clk),
        .rst_x     (rst_x),
        .i_req     (i_req),
        .i_last    (i_last),
        .i_dt      (i_dt),
        .o_ack     (o_ack),
        .o_wstrobe (o_wstrobe),
        .o_dt      (o_dt),
        .i_full    (i_full),
        .i_dnum    (i_dnum),
        .o_grant   (o_grant),
        .o_busy    (o_busy),
        .o_pkt_cnt (o_pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int               src;
        logic [WIDTH-1:0] dt;
        logic             last;
    } word_t;

    word_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, advanced once per cycle by the monitor.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;

    // Driver state per requester.
    logic [2:0]       req_r;
    logic [2:0]       last_r;
    logic [WIDTH-1:0] dt_r [3];
    int pkts_left [3];
    int words_left [3];
    int words_sent [3];
    int gap_cnt [3];
    int wait_cnt [3];
    int min_len, max_len, full_pct, bubble_pct, gap_max;
    int issued_since_reset = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] onehot(input int idx);
        logic [2:0] v;
        v = 3'b000;
        if (idx == 0) v = 3'b001;
        if (idx == 1) v = 3'b010;
        if (idx == 2) v = 3'b100;
        return v;
    endfunction

    task automatic monitor_cycle();
        logic [2:0] exp_grant;
        logic [2:0] exp_ack;
        logic [2:0] req;
        int         idx;
        int         cand;
        bit         found;
        req       = i_req;
        exp_grant = m_busy ? onehot(m_owner) : 3'b000;
        exp_ack   = 3'b000;
        if (m_busy && (req & onehot(m_owner)) != 3'b000 && !i_full) exp_ack = onehot(m_owner);
        check("grant", 32'(o_grant), 32'(exp_grant));
        check("busy", 32'(o_busy), 32'(m_busy));
        check("pkt_cnt", 32'(o_pkt_cnt), 32'(m_cnt[15:0]));
        check("ack", 32'(o_ack), 32'(exp_ack));
        check("wstrobe", 32'(o_wstrobe), 32'(|exp_ack));
        if (|exp_ack) begin
            idx = -1;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (idx < 0 && exp_q[i].src == m_owner) idx = i;
            end
            if (idx < 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL dt_order: write from requester %0d with no queued word at %0t", m_owner, $time);
            end else begin
                check("dt", o_dt, exp_q[idx].dt);
                if (exp_q[idx].last) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_owner + 1) % 3;
                    m_cnt  = (m_cnt + 1) % 65536;
                end
                exp_q.delete(idx);
            end
        end else if (!m_busy && req != 3'b000) begin
            found = 1'b0;
            for (int k = 0; k < 3; k++) begin
                cand = (m_ptr + k) % 3;
                if (!found && (req & onehot(cand)) != 3'b000) begin
                    found   = 1'b1;
                    m_owner = cand;
                end
            end
            m_busy = 1'b1;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_x) begin
                m_busy  = 1'b0;
                m_owner = 0;
                m_ptr   = 0;
                m_cnt   = 0;
                exp_q.delete();
            end else begin
                monitor_cycle();
            end
        end
    end

    task automatic clear_driver();
        req_r  = 3'b000;
        last_r = 3'b000;
        for (int n = 0; n < 3; n++) begin
            dt_r[n]       = '0;
            pkts_left[n]  = 0;
            words_left[n] = 0;
            words_sent[n] = 0;
            gap_cnt[n]    = 0;
            wait_cnt[n]   = 0;
        end
        i_req  = 3'b000;
        i_last = 3'b000;
        i_dt   = '0;
        i_full = 1'b0;
    endtask

    task automatic applyStimulus();
        logic [2:0] ack_seen;
        @(negedge clk);
        ack_seen = o_ack;
        @(posedge clk);
        #1;
        i_full = ($urandom_range(0, 99) < full_pct);
        i_dnum = 3'($urandom_range(0, 4));
        for (int n = 0; n < 3; n++) begin
            if (req_r[n] && ack_seen[n]) begin
                req_r[n]      = 1'b0;
                words_left[n] = words_left[n] - 1;
                words_sent[n] = words_sent[n] + 1;
                wait_cnt[n]   = 0;
                if (words_left[n] == 0) gap_cnt[n] = $urandom_range(0, gap_max);
            end
            if (req_r[n]) begin
                wait_cnt[n] = wait_cnt[n] + 1;
                if (wait_cnt[n] > 400) begin
                    n_tests++;
                    n_fail++;
                    $display("[TB] FAIL ack_timeout: requester %0d never acked at %0t", n, $time);
                    req_r[n]      = 1'b0;
                    words_left[n] = 0;
                    pkts_left[n]  = 0;
                end
            end else if (gap_cnt[n] > 0) begin
                gap_cnt[n] = gap_cnt[n] - 1;
            end else begin
                if (words_left[n] == 0 && pkts_left[n] > 0) begin
                    words_left[n] = $urandom_range(min_len, max_len);
                    words_sent[n] = 0;
                    pkts_left[n]  = pkts_left[n] - 1;
                    issued_since_reset++;
                end
                if (words_left[n] > 0) begin
                    if (words_sent[n] > 0 && $urandom_range(0, 99) < bubble_pct) begin
                        gap_cnt[n] = $urandom_range(1, 3);
                    end else begin
                        req_r[n]  = 1'b1;
                        last_r[n] = (words_left[n] == 1);
                        dt_r[n]   = $urandom;
                        exp_q.push_back('{src: n, dt: dt_r[n], last: last_r[n]});
                    end
                end
            end
        end
        i_req  = req_r;
        i_last = last_r;
        i_dt   = {dt_r[2], dt_r[1], dt_r[0]};
    endtask

    task automatic config_phase(input int p0, input int p1, input int p2, input int lmin,
                                input int lmax, input int fpct, input int bpct, input int gmax);
        pkts_left[0] = p0;
        pkts_left[1] = p1;
        pkts_left[2] = p2;
        min_len    = lmin;
        max_len    = lmax;
        full_pct   = fpct;
        bubble_pct = bpct;
        gap_max    = gmax;
    endtask

    function automatic bit all_done();
        bit d;
        d = (req_r == 3'b000) && (exp_q.size() == 0) && !m_busy;
        for (int n = 0; n < 3; n++) begin
            if (pkts_left[n] != 0 || words_left[n] != 0) d = 1'b0;
        end
        return d;
    endfunction

    task automatic drain(input string name);
        int cycles;
        cycles = 0;
        while (!all_done() && cycles < 6000) begin
            applyStimulus();
            cycles++;
        end
        if (!all_done()) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL %s_timeout: traffic did not complete within 6000 cycles", name);
        end
    endtask

    task automatic checkOutput(input string name);
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({name, "_pkt_total"}, 32'(o_pkt_cnt), 32'(issued_since_reset[15:0]));
    endtask

    initial begin
        #2_000_000;
        n_tests++;
        n_fail++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cycles;
        rst_x  = 1'b0;
        i_dnum = '0;
        clear_driver();
        config_phase(0, 0, 0, 1, 1, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(o_grant), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_pkt_cnt", 32'(o_pkt_cnt), 32'd0);
        check("rst_ack", 32'(o_ack), 32'd0);
        check("rst_wstrobe", 32'(o_wstrobe), 32'd0);
        check("rst_dt", o_dt, 32'd0);
        #2 rst_x = 1'b1;

        // Fairness: all three continuously requesting 2-word packets, FIFO never full.
        config_phase(4, 4, 4, 2, 2, 0, 0, 0);
        drain("fair");
        checkOutput("fair");

        // Stress: mixed packet lengths, FIFO stalls, owner bubbles and inter-packet gaps.
        config_phase(20, 20, 20, 1, 5, 25, 15, 3);
        drain("stress");
        checkOutput("stress");

        // Single-word packets alternating between requesters 0 and 2.
        config_phase(10, 0, 10, 1, 1, 10, 0, 1);
        drain("single");
        checkOutput("single");

        // Reset in the middle of a packet.
        config_phase(3, 3, 3, 4, 6, 0, 0, 0);
        cycles = 0;
        while (!o_busy && cycles < 50) begin
            applyStimulus();
            cycles++;
        end
        check("pre_reset_busy", 32'(o_busy), 32'd1);
        #2 rst_x = 1'b0;
        #1;
        check("async_rst_grant", 32'(o_grant), 32'd0);
        check("async_rst_busy", 32'(o_busy), 32'd0);
        check("async_rst_wstrobe", 32'(o_wstrobe), 32'd0);
        check("async_rst_ack", 32'(o_ack), 32'd0);
        check("async_rst_pkt_cnt", 32'(o_pkt_cnt), 32'd0);
        clear_driver();
        issued_since_reset = 0;
        @(negedge clk);
        #2 rst_x = 1'b1;

        // After reset all three request together; arbitration restarts at requester 0.
        config_phase(2, 2, 2, 2, 3, 0, 0, 0);
        applyStimulus();
        applyStimulus();
        check("restart_grant", 32'(o_grant), 32'd1);
        drain("restart");
        checkOutput("restart");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
